// File: rtl/regfile_reader.sv
// regfile_reader
//   Read side of the 32-entry CPU register file. It holds 32 registers of WIDTH
//   bits and accepts one write per cycle. Register ZERO_REG always reads as zero,
//   and writes to it are dropped. Two registered read ports forward a write made
//   in the same cycle. A debug scan engine streams all 32 registers, in order,
//   over a valid/ready channel.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-low; clears every register and the scan engine
//   writeEnable  write strobe for wr_addr / wr_data
//   wr_addr      write register index
//   wr_data      write data
//   rd_addr_a/b  read port indices
//   rd_data_a/b  registered read data, one cycle after the address
//   scan_start   pulse to begin a 32-beat dump (ignored while busy)
//   scan_valid   scan_data / scan_idx hold a beat
//   scan_ready   consumer accepts the beat when scan_valid is also high
//   scan_data    streamed register value
//   scan_idx     index of the streamed register
//   scan_busy    scan engine is not idle
module regfile_reader #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEnable,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [4:0]       rd_addr_a,
  input  logic [4:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             scan_start,
  output logic             scan_valid,
  input  logic             scan_ready,
  output logic [WIDTH-1:0] scan_data,
  output logic [4:0]       scan_idx,
  output logic             scan_busy
);

  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);
  localparam logic [4:0] LAST_IDX = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } scan_state_t;

  scan_state_t      state;
  scan_state_t      next_state;
  logic [4:0]       ptr;
  logic [4:0]       next_ptr;
  logic [WIDTH-1:0] regs [32];
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] fwd_scan;

  // Effective value of each read index. The zero register wins over
  // forwarding, so a write aimed at it can never leak through.
  always_comb begin
    fwd_a    = '0;
    fwd_b    = '0;
    fwd_scan = '0;
    if (rd_addr_a != ZERO_IDX) begin
      fwd_a = (writeEnable && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    end
    if (rd_addr_b != ZERO_IDX) begin
      fwd_b = (writeEnable && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
    end
    if (ptr != ZERO_IDX) begin
      fwd_scan = (writeEnable && wr_addr == ptr) ? wr_data : regs[ptr];
    end
  end

  // Register array. Writes to the zero register are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEnable && wr_addr != ZERO_IDX) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Registered read ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= fwd_a;
      rd_data_b <= fwd_b;
    end
  end

  // Scan engine state and pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // The beat is captured only in LOAD. It is therefore frozen for all of
  // SEND, so a later write to the same register cannot change a beat in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_data <= '0;
      scan_idx  <= '0;
    end else if (state == LOAD) begin
      scan_data <= fwd_scan;
      scan_idx  <= ptr;
    end
  end

  // Next-state logic. Going through LOAD -> SEND for every register gives
  // at most one beat every two cycles.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      IDLE: begin
        if (scan_start) begin
          next_state = LOAD;
          next_ptr   = '0;
        end
      end
      LOAD: begin
        next_state = SEND;
      end
      SEND: begin
        if (scan_ready) begin
          if (ptr == LAST_IDX) begin
            next_state = IDLE;
          end else begin
            next_state = LOAD;
            next_ptr   = ptr + 5'd1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign scan_valid = (state == SEND);
  assign scan_busy  = (state != IDLE);

endmodule
